// File: rtl/rc4_pkg.sv
// Shared constants and types for the receive-side RC4 stream engine.
package rc4_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned S_SIZE      = 256;
    localparam int unsigned INIT_CYCLES = 256;
    localparam int unsigned KSA_CYCLES  = 256;

    typedef logic [BYTE_W-1:0] rc4_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_READY,
        ST_SWAP,
        ST_OUT
    } rc4_state_t;

endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation store: three combinational read ports, one swap write or
// identity-fill write per cycle.
module rc4_sbox
    import rc4_pkg::*;
#(
    parameter int unsigned DEPTH = S_SIZE
) (
    input  logic      clk,
    input  logic      i_init_we,
    input  logic      i_swap_we,
    input  rc4_byte_t i_addr_a,
    input  rc4_byte_t i_addr_b,
    input  rc4_byte_t i_addr_k,
    output rc4_byte_t o_rd_a,
    output rc4_byte_t o_rd_b,
    output rc4_byte_t o_rd_k
);

    rc4_byte_t r_s [DEPTH];

    assign o_rd_a = r_s[i_addr_a];
    assign o_rd_b = r_s[i_addr_b];
    assign o_rd_k = r_s[i_addr_k];

    // Contents are meaningless until the identity fill has run, so no reset.
    always_ff @(posedge clk) begin
        if (i_init_we) begin
            r_s[i_addr_a] <= i_addr_a;
        end else if (i_swap_we) begin
            r_s[i_addr_a] <= o_rd_b;
            r_s[i_addr_b] <= o_rd_a;
        end
    end

endmodule

// File: rtl/rc4_decrypt.sv
// Receive-side RC4 engine: schedules S from a loaded key, then XORs one
// keystream byte onto each accepted ciphertext byte.
module rc4_decrypt
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = 16,
    parameter int unsigned S_SIZE    = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [4:0]             key_len,
    input  logic                   key_load,
    output logic                   ksa_done,
    output logic                   key_err,
    input  logic                   ct_valid,
    input  rc4_byte_t              ct_data,
    output logic                   ct_ready,
    output logic                   pt_valid,
    output rc4_byte_t              pt_data,
    input  logic                   pt_ready
);

    localparam int unsigned KEY_W     = 8 * KEY_BYTES;
    localparam int unsigned KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [4:0]  MAX_LEN   = 5'(KEY_BYTES);
    localparam rc4_byte_t   INIT_LAST = 8'(INIT_CYCLES - 1);
    localparam rc4_byte_t   KSA_LAST  = 8'(KSA_CYCLES - 1);

    rc4_state_t        r_state, w_state_next;
    rc4_byte_t         r_i, w_i_next;
    rc4_byte_t         r_j, w_j_next;
    logic [KIDX_W-1:0] r_key_idx, w_key_idx_next;
    logic [KEY_W-1:0]  r_key, w_key_next;
    logic [4:0]        r_key_len, w_key_len_next;
    rc4_byte_t         r_ct_byte, w_ct_byte_next;
    rc4_byte_t         r_pt_data, w_pt_data_next;
    logic              r_pt_valid, w_pt_valid_next;
    logic              r_ksa_done, w_ksa_done_next;
    logic              r_key_err, w_key_err_next;

    logic              w_init_we, w_swap_we;
    rc4_byte_t         w_addr_a, w_addr_b, w_addr_k;
    rc4_byte_t         w_rd_a, w_rd_b, w_rd_k;
    rc4_byte_t         w_i_inc, w_j_new, w_key_byte, w_key_add;
    logic              w_key_ok, w_key_idx_last, w_ct_fire;

    rc4_sbox #(
        .DEPTH (S_SIZE)
    ) u_sbox (
        .clk       (clk),
        .i_init_we (w_init_we),
        .i_swap_we (w_swap_we),
        .i_addr_a  (w_addr_a),
        .i_addr_b  (w_addr_b),
        .i_addr_k  (w_addr_k),
        .o_rd_a    (w_rd_a),
        .o_rd_b    (w_rd_b),
        .o_rd_k    (w_rd_k)
    );

    // Port A reads S[i] (S[i+1] while swapping), port B reads S[new j] or S[j]
    // at output time, port K reads S[S[i]+S[j]] for the keystream byte.
    assign w_key_byte     = r_key[{r_key_idx, 3'b000} +: 8];
    assign w_key_add      = (r_state == ST_KSA) ? w_key_byte : 8'd0;
    assign w_i_inc        = r_i + 8'd1;
    assign w_addr_a       = (r_state == ST_SWAP) ? w_i_inc : r_i;
    assign w_j_new        = r_j + w_rd_a + w_key_add;
    assign w_addr_b       = (r_state == ST_OUT) ? r_j : w_j_new;
    assign w_addr_k       = w_rd_a + w_rd_b;

    assign w_key_ok       = (key_len != 5'd0) && (key_len <= MAX_LEN);
    assign w_key_idx_last = (5'(r_key_idx) == (r_key_len - 5'd1));
    assign ct_ready       = (r_state == ST_READY) && (!r_pt_valid || pt_ready);
    assign w_ct_fire      = ct_valid && ct_ready;

    assign ksa_done = r_ksa_done;
    assign key_err  = r_key_err;
    assign pt_valid = r_pt_valid;
    assign pt_data  = r_pt_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (key_load) begin
            w_state_next = w_key_ok ? ST_INIT : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_next = ST_IDLE;
                ST_INIT:  if (r_i == INIT_LAST) w_state_next = ST_KSA;
                ST_KSA:   if (r_i == KSA_LAST) w_state_next = ST_READY;
                ST_READY: if (w_ct_fire) w_state_next = ST_SWAP;
                ST_SWAP:  w_state_next = ST_OUT;
                ST_OUT:   w_state_next = ST_READY;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // A key load overrides everything, dropping any byte still in flight.
    always_comb begin
        w_i_next        = r_i;
        w_j_next        = r_j;
        w_key_idx_next  = r_key_idx;
        w_key_next      = r_key;
        w_key_len_next  = r_key_len;
        w_ct_byte_next  = r_ct_byte;
        w_pt_data_next  = r_pt_data;
        w_pt_valid_next = r_pt_valid && !pt_ready;
        w_ksa_done_next = r_ksa_done;
        w_key_err_next  = r_key_err;
        w_init_we       = 1'b0;
        w_swap_we       = 1'b0;
        if (key_load) begin
            w_key_next      = key;
            w_key_len_next  = key_len;
            w_i_next        = '0;
            w_j_next        = '0;
            w_key_idx_next  = '0;
            w_pt_valid_next = 1'b0;
            w_ksa_done_next = 1'b0;
            w_key_err_next  = !w_key_ok;
        end else begin
            case (r_state)
                ST_INIT: begin
                    w_init_we = 1'b1;
                    w_i_next  = w_i_inc;
                end
                ST_KSA: begin
                    w_swap_we      = 1'b1;
                    w_i_next       = w_i_inc;
                    w_j_next       = w_j_new;
                    w_key_idx_next = w_key_idx_last ? '0 : r_key_idx + KIDX_W'(1);
                    if (r_i == KSA_LAST) begin
                        w_i_next        = '0;
                        w_j_next        = '0;
                        w_ksa_done_next = 1'b1;
                    end
                end
                ST_READY: begin
                    if (w_ct_fire) w_ct_byte_next = ct_data;
                end
                ST_SWAP: begin
                    w_swap_we = 1'b1;
                    w_i_next  = w_i_inc;
                    w_j_next  = w_j_new;
                end
                ST_OUT: begin
                    w_pt_data_next  = r_ct_byte ^ w_rd_k;
                    w_pt_valid_next = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i        <= '0;
            r_j        <= '0;
            r_key_idx  <= '0;
            r_key      <= '0;
            r_key_len  <= '0;
            r_ct_byte  <= '0;
            r_pt_data  <= '0;
            r_pt_valid <= 1'b0;
            r_ksa_done <= 1'b0;
            r_key_err  <= 1'b0;
        end else begin
            r_i        <= w_i_next;
            r_j        <= w_j_next;
            r_key_idx  <= w_key_idx_next;
            r_key      <= w_key_next;
            r_key_len  <= w_key_len_next;
            r_ct_byte  <= w_ct_byte_next;
            r_pt_data  <= w_pt_data_next;
            r_pt_valid <= w_pt_valid_next;
            r_ksa_done <= w_ksa_done_next;
            r_key_err  <= w_key_err_next;
        end
    end

endmodule

// File: tb/tb_rc4_decrypt.sv
// Self-checking bench for rc4_decrypt: textbook RC4 model plus a cycle-level
// expectation of the handshake, with literal known-answer vectors.
module tb_rc4_decrypt;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [127:0] key = '0;
    logic [4:0]   key_len = '0;
    logic         key_load = 1'b0;
    logic         ksa_done, key_err, ct_ready, pt_valid;
    logic         ct_valid = 1'b0;
    logic [7:0]   ct_data = '0;
    logic [7:0]   pt_data;
    logic         pt_ready = 1'b0;

    rc4_decrypt #(.KEY_BYTES(16), .S_SIZE(256)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .key_len  (key_len),
        .key_load (key_load),
        .ksa_done (ksa_done),
        .key_err  (key_err),
        .ct_valid (ct_valid),
        .ct_data  (ct_data),
        .ct_ready (ct_ready),
        .pt_valid (pt_valid),
        .pt_data  (pt_data),
        .pt_ready (pt_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Textbook RC4 on plain integer arrays.
    int ms[256];
    int mi, mj;

    task automatic model_ksa(input logic [127:0] k, input int len);
        int j, t;
        for (int i = 0; i < 256; i++) ms[i] = i;
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + ms[i] + int'(k[8*(i % len) +: 8])) % 256;
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
        end
        mi = 0;
        mj = 0;
    endtask

    function automatic int model_prga();
        int t;
        mi = (mi + 1) % 256;
        mj = (mj + ms[mi]) % 256;
        t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
        return ms[(ms[mi] + ms[mj]) % 256];
    endfunction

    // Expected DUT state after the upcoming edge, plus stream bookkeeping.
    logic       e_pt_valid = 0, e_ksa_done = 0, e_key_err = 0, e_ready;
    logic [7:0] e_pt_data = 0, pend_data = 0;
    int         pend = 0, cyc = 0, acc_cnt = 0, lenv;
    bit         key_ok_m = 0;
    logic [7:0] got_q[$];
    logic [7:0] ct_q[$];
    int         s_base = 0;

    initial begin : compare
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                chk("rst_pt_valid", pt_valid, 0);
                chk("rst_pt_data", pt_data, 0);
                chk("rst_ksa_done", ksa_done, 0);
                chk("rst_key_err", key_err, 0);
                chk("rst_ct_ready", ct_ready, 0);
                e_pt_valid = 0; e_pt_data = 0; e_ksa_done = 0; e_key_err = 0;
                pend = 0; cyc = 0; key_ok_m = 0;
            end else begin
                e_ready = e_ksa_done && (pend == 0) && (!e_pt_valid || pt_ready);
                chk("pt_valid", pt_valid, e_pt_valid);
                if (e_pt_valid) chk("pt_data", pt_data, e_pt_data);
                chk("ksa_done", ksa_done, e_ksa_done);
                chk("key_err", key_err, e_key_err);
                chk("ct_ready", ct_ready, e_ready);
                if (key_load) begin
                    lenv = int'(key_len);
                    key_ok_m = (lenv >= 1) && (lenv <= 16);
                    if (key_ok_m) model_ksa(key, lenv);
                    e_key_err = !key_ok_m;
                    e_ksa_done = 0; e_pt_valid = 0; pend = 0; cyc = 0;
                end else begin
                    if (e_pt_valid && pt_ready) begin
                        got_q.push_back(pt_data);
                        e_pt_valid = 0;
                    end
                    if (pend > 0) begin
                        pend--;
                        if (pend == 0) begin
                            e_pt_valid = 1;
                            e_pt_data = pend_data;
                        end
                    end
                    if (ct_valid && e_ready) begin
                        pend_data = ct_data ^ 8'(model_prga());
                        pend = 2;
                        acc_cnt++;
                    end
                    if (key_ok_m) begin
                        if (cyc < 1000) cyc++;
                        e_ksa_done = (cyc >= 512);
                    end
                end
            end
        end
    end

    task automatic load_key(input logic [127:0] k, input int len);
        @(negedge clk);
        key = k; key_len = 5'(len); key_load = 1'b1; ct_valid = 1'b0;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    task automatic wait_ksa(output int n);
        n = 0;
        while (!ksa_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ksa_wait", ksa_done, 1);
    endtask

    task automatic begin_stream(input logic [7:0] q[$]);
        ct_q = q;
        s_base = acc_cnt;
        got_q.delete();
    endtask

    task automatic stream(input int vld_pct, input int rdy_pct, input int stop_after);
        int n = 0;
        int idx;
        while (got_q.size() < stop_after && n < 3000) begin
            @(negedge clk);
            n++;
            idx = acc_cnt - s_base;
            if (idx < ct_q.size() && $urandom_range(99) < vld_pct) begin
                ct_valid = 1'b1; ct_data = ct_q[idx];
            end else begin
                ct_valid = 1'b0; ct_data = 8'($urandom);
            end
            pt_ready = ($urandom_range(99) < rdy_pct);
        end
        ct_valid = 1'b0;
        chk("stream_count", got_q.size(), stop_after);
    endtask

    task automatic check_got(input string name, input logic [7:0] exp[$]);
        logic [7:0] g;
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'h00;
            chk(name, g, exp[i]);
        end
    endtask

    logic [127:0] v1_key = 128'h79654B;
    logic [127:0] v2_key = 128'h696B6957;
    logic [7:0] v1_ct[$] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] v1_pt[$] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] v2_ct[$] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    logic [7:0] v2_pt[$] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        logic [7:0] rq[$];
        logic [127:0] rk;
        int rl;

        // Pin the model against the published vectors before it is used live.
        model_ksa(v1_key, 3);
        for (int i = 0; i < v1_ct.size(); i++)
            chk("model_v1", int'(v1_ct[i] ^ 8'(model_prga())), int'(v1_pt[i]));
        model_ksa(v2_key, 4);
        for (int i = 0; i < v2_ct.size(); i++)
            chk("model_v2", int'(v2_ct[i] ^ 8'(model_prga())), int'(v2_pt[i]));

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pt_ready = 1'b1;

        // Vector 1 with exact schedule latency.
        load_key(v1_key, 3);
        wait_ksa(n);
        chk("ksa_latency", n, 512);
        begin_stream(v1_ct);
        stream(70, 70, 9);
        check_got("v1_plain", v1_pt);

        // Vector 2.
        load_key(v2_key, 4);
        wait_ksa(n);
        begin_stream(v2_ct);
        stream(100, 100, 5);
        check_got("v2_plain", v2_pt);

        // Backpressure: hold the first plaintext for 10 cycles.
        load_key(v1_key, 3);
        wait_ksa(n);
        begin_stream(v1_ct);
        pt_ready = 1'b0;
        n = 0;
        while (!pt_valid && n < 50) begin
            @(negedge clk);
            n++;
            ct_valid = 1'b1;
            ct_data = ct_q[acc_cnt - s_base];
        end
        chk("bp_first_valid", pt_valid, 1);
        repeat (10) begin
            @(negedge clk);
            ct_valid = 1'b1;
            ct_data = ct_q[1];
            chk("bp_ct_ready", ct_ready, 0);
            chk("bp_pt_data", pt_data, 8'h50);
            chk("bp_accepted", acc_cnt - s_base, 1);
        end
        stream(100, 100, 9);
        check_got("bp_plain", v1_pt);

        // Mid-stream rekey.
        load_key(v1_key, 3);
        wait_ksa(n);
        begin_stream(v1_ct);
        stream(90, 80, 3);
        check_got("rk_first3", '{8'h50, 8'h6C, 8'h61});
        load_key(v2_key, 4);
        chk("rk_pt_valid", pt_valid, 0);
        chk("rk_ksa_done", ksa_done, 0);
        wait_ksa(n);
        chk("rk_ksa_latency", n, 512);
        begin_stream(v2_ct);
        stream(60, 60, 5);
        check_got("rk_v2_plain", v2_pt);

        // Bad key lengths.
        load_key(v1_key, 0);
        ct_valid = 1'b1;
        chk("bad0_key_err", key_err, 1);
        chk("bad0_ksa_done", ksa_done, 0);
        chk("bad0_ct_ready", ct_ready, 0);
        repeat (5) @(negedge clk);
        chk("bad0_hold", key_err, 1);
        load_key(v1_key, 17);
        chk("bad17_key_err", key_err, 1);
        chk("bad17_ct_ready", ct_ready, 0);
        load_key(v2_key, 4);
        chk("good_clears_err", key_err, 0);
        wait_ksa(n);

        // Asynchronous reset in the middle of the schedule.
        load_key(v1_key, 3);
        repeat (300) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pt_valid", pt_valid, 0);
        chk("arst_pt_data", pt_data, 0);
        chk("arst_ksa_done", ksa_done, 0);
        chk("arst_key_err", key_err, 0);
        chk("arst_ct_ready", ct_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        load_key(v1_key, 3);
        wait_ksa(n);
        begin_stream(v1_ct);
        stream(80, 50, 9);
        check_got("arst_v1_plain", v1_pt);

        // Random keys and ciphertext under random handshake pressure.
        for (int r = 0; r < 6; r++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rl = $urandom_range(16, 1);
            load_key(rk, rl);
            wait_ksa(n);
            rq.delete();
            for (int b = 0; b < 16; b++) rq.push_back(8'($urandom));
            begin_stream(rq);
            stream($urandom_range(100, 30), $urandom_range(100, 30), 16);
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rc4_decrypt.md
Name: rc4_decrypt

Overview:
Receive-side RC4 stream engine.
- Accepts ciphertext bytes from the encrypted-data FIFO side over a valid/ready handshake.
- Regenerates the RC4 keystream from a loaded key: KSA once per key, then PRGA once per byte.
- XORs the keystream with each ciphertext byte and emits plaintext over a valid/ready handshake.
- Self-contained: owns its own S-box, so it runs alongside the transmit-side encryptor without sharing state.

Parameters:
KEY_BYTES, 16, maximum key length in bytes; sets the key port width.
S_SIZE, 256, S-box depth; fixed by RC4 and not to be overridden.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
key  input  8*KEY_BYTES  key bytes; byte n on key[8n+7:8n]
key_len  input  5  valid key length in bytes, 1..KEY_BYTES
key_load  input  1  one-cycle pulse: latch key/key_len and restart the schedule
ksa_done  output  1  high when S is scheduled and the block is accepting bytes
key_err  output  1  high after a key_load with key_len==0 or key_len>KEY_BYTES
ct_valid  input  1  ciphertext byte valid
ct_data  input  8  ciphertext byte
ct_ready  output  1  block accepts ct_data this cycle
pt_valid  output  1  plaintext byte valid
pt_data  output  8  plaintext byte
pt_ready  input  1  downstream consumes pt_data this cycle

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; i=j=0; key_idx=0.
  - ksa_done=0, key_err=0, ct_ready=0, pt_valid=0, pt_data=0.
  - S contents are don't-care.
- FSM states: IDLE, INIT, KSA, READY, SWAP, OUT.
- IDLE: waits for key_load.
- key_load handling (accepted in every state; it has highest priority):
  - Latch key and key_len; clear i, j, key_idx and pt_valid.
  - Discard any in-flight byte.
  - If key_len is valid: go to INIT and clear key_err.
  - If key_len is invalid: go to IDLE and set key_err. key_err stays set until the next key_load.
- INIT, 256 cycles: S[i]=i, i increments each cycle. After i=255, i wraps to 0 and the FSM goes to KSA.
- KSA, 256 cycles, one iteration per cycle:
  - j = j + S[i] + key[key_idx] (mod 256), then swap S[i] and S[j].
  - key_idx wraps at key_len-1 using a counter, no divider.
  - After i=255: go to READY, set i=j=0 and ksa_done=1.
- READY:
  - ct_ready = (state==READY) && (!pt_valid || pt_ready).
  - On handshake, latch ct_data and go to SWAP.
- SWAP, one cycle: i=i+1, j=j+S[i+1] (mod 256), swap S[i] and S[j]. All mod-256 arithmetic uses an 8-bit natural wrap.
- OUT, one cycle:
  - Keystream K = S[(S[i]+S[j]) mod 256].
  - Register pt_data = ct_byte ^ K and set pt_valid=1. Return to READY.
- Latency: the accepting edge is E. pt_valid is high after edge E+2. Peak throughput is one byte per 3 cycles.
- Output hold: pt_valid/pt_data stay stable until pt_ready. pt_valid clears on the consuming edge unless a new byte is loaded on that same edge.
- Simultaneous pt_ready and ct handshake in READY: both complete. pt_valid drops and the new byte proceeds.
- ksa_done drops on key_load and rises again only on entry to READY.
- Keystream continuity: keystream position advances only on accepted bytes. ct_valid while not ready is ignored, with no loss and no advance.

Decomposition:
- Package rc4_pkg holds:
  - the state enum type;
  - S_SIZE;
  - byte typedef;
  - localparams INIT_CYCLES=256 and KSA_CYCLES=256.
- Sub-module rc4_sbox:
  - 256x8 register array;
  - two combinational read ports plus a third for the keystream index;
  - single swap-write strobe with two addresses;
  - init-write mode (S[addr]=addr).
- rc4_decrypt holds the FSM, i/j/key_idx counters, handshake and XOR.

Test Plan:
- Known vector 1: key=4B 65 79 ("Key"), key_len=3; ciphertext BB F3 16 E8 D9 40 AF 0A D3 -> plaintext 50 6C 61 69 6E 74 65 78 74 ("Plaintext"). ksa_done rises exactly 512 cycles after the key_load edge.
- Known vector 2: key=57 69 6B 69 ("Wiki"), key_len=4; ciphertext 10 21 BF 04 20 -> 70 65 64 69 61 ("pedia").
- Backpressure: vector 1 with pt_ready low for 10 cycles after the first byte. ct_ready stays 0, pt_data holds 50, and the remaining bytes still decode correctly in order.
- Mid-stream rekey: after 3 bytes of vector 1, pulse key_load with "Wiki". pt_valid clears, ksa_done falls, then vector 2 decodes correctly from its first byte.
- Bad key: key_load with key_len=0 -> key_err=1, ksa_done=0, ct_ready=0. key_len=17 gives the same result. A following valid key_load clears key_err.
- Async reset mid-KSA: drop rst_n at cycle 300 after key_load. All outputs go to 0 immediately. After reload, vector 1 decodes correctly.
